// File: rtl/ssd_scan_if.sv
// ============================================================================
//  Module      : ssd_scan_if
//  Description : Display-side bundle between a host and ssd_scan_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ssd_scan_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  dig_en;
  logic [3:0]  nibble;
  logic        dp_out;
  logic [3:0]  an;
  logic        pending;
  logic        frame_tick;

  modport master (
    output load, value, dp_in, dig_en,
    input  nibble, dp_out, an, pending, frame_tick
  );

  modport slave (
    input  load, value, dp_in, dig_en,
    output nibble, dp_out, an, pending, frame_tick
  );
endinterface

`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
// ============================================================================
//  Module      : ssd_scan_ctrl
//  Description : 4-digit hex scan controller for a single-digit 7-seg decoder,
//                double-buffered with frame-boundary commit and slot blanking.
//                Optional macro SSD_LEAD_ZERO_BLANK_EN darkens leading zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd_scan_ctrl #(
  parameter int CNT_W     = 16,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  ssd_scan_if.slave   sif
);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      disp_q, disp_d;
  logic [3:0]       disp_dp_q, disp_dp_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic             pending_q, pending_d;
  logic             frame_tick_q, frame_tick_d;

  logic             w_in_blank;
  logic [0:0]       w_phase;
  logic             w_last_slot;
  logic             w_commit;
  logic             w_lz_dark;

  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign w_in_blank = 1'b0;
    end else begin : g_blank
      assign w_in_blank = (cnt_q < CNT_W'(BLANK_CYC));
    end
  endgenerate

  assign w_phase     = w_in_blank ? ST_BLANK : ST_SHOW;
  assign w_last_slot = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign w_commit    = w_last_slot && (idx_q == 2'd3);

`ifdef SSD_LEAD_ZERO_BLANK_EN
  // A digit is dark only if it and every higher digit of the committed value are zero.
  always_comb begin
    w_lz_dark = 1'b0;
    case (idx_q)
      2'd3:    w_lz_dark = (disp_q[15:12] == 4'h0);
      2'd2:    w_lz_dark = (disp_q[15:8]  == 8'h00);
      2'd1:    w_lz_dark = (disp_q[15:4]  == 12'h000);
      default: w_lz_dark = 1'b0;
    endcase
  end
`else
  assign w_lz_dark = 1'b0;
`endif

  always_comb begin
    cnt_d        = w_last_slot ? '0 : cnt_q + 1'b1;
    idx_d        = w_last_slot ? idx_q + 2'd1 : idx_q;
    disp_d       = disp_q;
    disp_dp_d    = disp_dp_q;
    shadow_d     = shadow_q;
    shadow_dp_d  = shadow_dp_q;
    pending_d    = pending_q;
    frame_tick_d = w_commit;

    if (sif.load) begin
      shadow_d    = sif.value;
      shadow_dp_d = sif.dp_in;
      pending_d   = 1'b1;
    end

    // A load on the commit cycle bypasses the shadow so the stale shadow never shows.
    if (w_commit) begin
      if (sif.load) begin
        disp_d    = sif.value;
        disp_dp_d = sif.dp_in;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        disp_dp_d = shadow_dp_q;
      end
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q        <= '0;
      cnt_q        <= '0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign sif.nibble     = disp_q[{idx_q, 2'b00} +: 4];
  assign sif.dp_out     = (w_phase == ST_SHOW) ? disp_dp_q[idx_q] : 1'b0;
  assign sif.an         = ((w_phase == ST_SHOW) && sif.dig_en[idx_q] && !w_lz_dark)
                          ? (4'b0001 << idx_q) : 4'b0000;
  assign sif.pending    = pending_q;
  assign sif.frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_ssd_scan_ctrl.sv
// ============================================================================
//  Module      : tb_ssd_scan_ctrl
//  Description : Randomized and directed bench for ssd_scan_ctrl against a
//                frame-position reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ssd_scan_ctrl;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 4 * SCAN_DIV;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ssd_scan_if sif ();

  ssd_scan_ctrl #(.CNT_W(3), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: position in frame plus committed/shadow contents.
  int          m_t;
  logic [15:0] m_disp, m_sh;
  logic [3:0]  m_dp, m_shdp;
  logic        m_pend, m_ft;
  logic [3:0]  cur_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic lz_dark(input int d, input logic [15:0] v);
`ifdef SSD_LEAD_ZERO_BLANK_EN
    return (d > 0) && ((v >> (4 * d)) == 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_t = 0; m_disp = '0; m_sh = '0; m_dp = '0; m_shdp = '0; m_pend = 0; m_ft = 0;
  endtask

  task automatic cycle(input logic rn, input logic ld, input logic [15:0] v,
                       input logic [3:0] dp, input logic [3:0] en);
    int d;
    logic show;
    logic [3:0] e_an;
    rst_n = rn; sif.load = ld; sif.value = v; sif.dp_in = dp; sif.dig_en = en;
    cur_en = en;
    #3;
    d    = m_t / SCAN_DIV;
    show = (m_t % SCAN_DIV) >= BLANK_CYC;
    e_an = (show && en[d] && !lz_dark(d, m_disp)) ? 4'(1 << d) : 4'b0000;
    check("an",         32'(sif.an),         32'(e_an));
    check("nibble",     32'(sif.nibble),     32'((m_disp >> (4 * d)) & 16'hF));
    check("dp_out",     32'(sif.dp_out),     32'(show ? m_dp[d] : 1'b0));
    check("pending",    32'(sif.pending),    32'(m_pend));
    check("frame_tick", 32'(sif.frame_tick), 32'(m_ft));
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      m_ft = (m_t == FRAME - 1);
      if (m_ft) begin
        if (ld) begin m_disp = v; m_dp = dp; end
        else if (m_pend) begin m_disp = m_sh; m_dp = m_shdp; end
        if (ld) begin m_sh = v; m_shdp = dp; end
        m_pend = 0;
      end else if (ld) begin
        m_sh = v; m_shdp = dp; m_pend = 1;
      end
      m_t = (m_t + 1) % FRAME;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0, 4'h0, cur_en);
  endtask

  task automatic run_to(input int target);
    int k = 0;
    while (m_t != target && k < 2 * FRAME) begin
      cycle(1'b1, 1'b0, 16'h0, 4'h0, cur_en);
      k++;
    end
    check("run_to_bound", 32'(m_t), 32'(target));
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] dp);
    cycle(1'b1, 1'b1, v, dp, cur_en);
  endtask

  initial begin
    logic [15:0] rv;
    model_reset();
    cur_en = 4'hF;
    rst_n = 1'b0; sif.load = 1'b0; sif.value = '0; sif.dp_in = '0; sif.dig_en = 4'hF;
    @(posedge clk); #1;
    cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'hF);
    cycle(1'b0, 1'b0, 16'h0, 4'h0, 4'hF);

    // First frame after reset: load 1234, commit at end of frame.
    idle(1);
    load(16'h1234, 4'h0);
    idle(40);

    // Free-run with ABCD and all digits enabled.
    load(16'hABCD, 4'h0);
    idle(2 * FRAME);

    // Two loads before commit: last wins.
    run_to(SCAN_DIV + 3);
    load(16'h5555, 4'h0);
    run_to(2 * SCAN_DIV + 1);
    load(16'h6666, 4'h0);
    idle(FRAME);

    // Load on the commit cycle bypasses a stale shadow.
    run_to(5);
    load(16'h1111, 4'h0);
    run_to(FRAME - 1);
    load(16'h7777, 4'h0);
    idle(FRAME);

    // Partial digit enable with all decimal points set.
    cur_en = 4'b0101;
    load(16'h9876, 4'hF);
    idle(2 * FRAME);

    // Reset during digit2 SHOW.
    cur_en = 4'hF;
    load(16'h4321, 4'h3);
    run_to(2 * SCAN_DIV + 4);
    cycle(1'b0, 1'b0, 16'h0, 4'h0, cur_en);
    idle(FRAME);

    // Leading-zero pattern.
    load(16'h0040, 4'h0);
    idle(2 * FRAME);

    // Randomized traffic including mid-slot dig_en changes and rare resets.
    for (int i = 0; i < 3000; i++) begin
      rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) cur_en = 4'($urandom);
      cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) == 0),
            rv, 4'($urandom), cur_en);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
